// File: rtl/fb_loader.sv
// fb_loader: byte-stream frame-buffer writer for the 128x128 RGB444 image memory.
// It waits for a start-of-frame marker, packs R,G,B byte triplets into 12-bit
// pixels and writes them in raster order. A write only happens while the display
// is blanked, so a frame being loaded never tears on screen.
module fb_loader #(
    parameter int         PIX_COUNT = 16384,
    parameter int         ADDR_W    = 14,
    parameter logic [7:0] SOF_BYTE  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              blank,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        GET_R,
        GET_G,
        GET_B,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIX_COUNT - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] pix_cnt;
    logic [7:0]        r_reg;
    logic [7:0]        g_reg;
    logic [7:0]        b_reg;
    logic              accept;

    // The block takes bytes only while hunting for the marker or collecting colours.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            SYNC, GET_R, GET_G, GET_B: in_ready = 1'b1;
            default:                   in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;

    // An abort in the WRITE cycle cancels the write so no partial pixel lands in memory.
    assign wr_en      = (state == WRITE) && blank && !abort;
    assign wr_addr    = pix_cnt;
    assign wr_data    = {r_reg[7:4], g_reg[7:4], b_reg[7:4]};
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    // Frame sequencer: marker hunt, colour capture, blank-gated write, end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pix_cnt <= '0;
            r_reg   <= '0;
            g_reg   <= '0;
            b_reg   <= '0;
        end else if (abort) begin
            state   <= IDLE;
            pix_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SYNC;
                        pix_cnt <= '0;
                    end
                end
                SYNC: begin
                    if (accept && (in_data == SOF_BYTE)) begin
                        state <= GET_R;
                    end
                end
                GET_R: begin
                    if (accept) begin
                        r_reg <= in_data;
                        state <= GET_G;
                    end
                end
                GET_G: begin
                    if (accept) begin
                        g_reg <= in_data;
                        state <= GET_B;
                    end
                end
                GET_B: begin
                    if (accept) begin
                        b_reg <= in_data;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (blank) begin
                        if (pix_cnt == LAST_PIX) begin
                            pix_cnt <= '0;
                            state   <= DONE;
                        end else begin
                            pix_cnt <= pix_cnt + ONE;
                            state   <= GET_R;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_loader.sv
// tb_fb_loader: directed scenarios for fb_loader with hand-derived expected writes.
`timescale 1ns/1ps
module tb_fb_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        blank = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [11:0] wr_data;
    logic        busy;
    logic        frame_done;

    int check_cnt = 0;
    int pass_cnt = 0;
    int timeout_cnt = 0;
    int cyc = 0;
    int fd_cnt = 0;
    int fd_cyc = 0;

    logic [13:0] wq_addr[$];
    logic [11:0] wq_data[$];
    int          wq_cyc[$];

    // 100 MHz clock
    always #5 clk = ~clk;

    fb_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .blank      (blank),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Cycle stamp for write spacing and frame_done timing
    always @(posedge clk) cyc <= cyc + 1;

    // Record every memory write and every frame_done pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
            wq_cyc.push_back(cyc);
        end
        if (frame_done === 1'b1) begin
            fd_cnt <= fd_cnt + 1;
            fd_cyc <= cyc;
        end
    end

    // Pixel colour pattern; marker value A5 appears inside the data on purpose
    function automatic logic [7:0] pr(input int i);
        return 8'(i * 7 + 3);
    endfunction
    function automatic logic [7:0] pg(input int i);
        return 8'(i * 13 + 8'hA5);
    endfunction
    function automatic logic [7:0] pb(input int i);
        return 8'((i >> 3) ^ 8'hA5);
    endfunction
    function automatic logic [11:0] pexp(input int i);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = pr(i);
        g = pg(i);
        b = pb(i);
        return {r[7:4], g[7:4], b[7:4]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // Present one byte and hold it until the accepting edge (bounded wait)
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1) begin
            waited++;
            if (waited > 200) begin
                timeout_cnt++;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_pixel(input int i);
        send_byte(pr(i));
        send_byte(pg(i));
        send_byte(pb(i));
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst_n = 1'b0; in_valid = 1'b1; start = 1'b1; in_data = 8'hA5; blank = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check_cnt++; if (in_ready !== 1'b0) $display("[TB] FAIL rst_in_ready: got %0b want 0", in_ready); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %0b want 0", busy); else pass_cnt++;
        check_cnt++; if (wr_en !== 1'b0) $display("[TB] FAIL rst_wr_en: got %0b want 0", wr_en); else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_cnt++; if (in_ready !== 1'b0) $display("[TB] FAIL idle_in_ready: got %0b want 0", in_ready); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL idle_busy: got %0b want 0", busy); else pass_cnt++;
        check_cnt++; if (wr_en !== 1'b0) $display("[TB] FAIL idle_wr_en: got %0b want 0", wr_en); else pass_cnt++;
        check_cnt++; if (wr_addr !== 14'h0) $display("[TB] FAIL idle_wr_addr: got %0h want 0", wr_addr); else pass_cnt++;
        check_cnt++; if (wr_data !== 12'h0) $display("[TB] FAIL idle_wr_data: got %0h want 0", wr_data); else pass_cnt++;
        check_cnt++; if (frame_done !== 1'b0) $display("[TB] FAIL idle_frame_done: got %0b want 0", frame_done); else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_cnt++; if (wq_addr.size() !== 0) $display("[TB] FAIL idle_no_writes: got %0d want 0", wq_addr.size()); else pass_cnt++;
    endtask

    task automatic test_sync_hunt();
        int base;
        $display("[TB] test_sync_hunt");
        blank = 1'b1;
        pulse_start();
        @(negedge clk);
        check_cnt++; if (busy !== 1'b1) $display("[TB] FAIL sync_busy: got %0b want 1", busy); else pass_cnt++;
        check_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL sync_in_ready: got %0b want 1", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        base = wq_addr.size();
        send_byte(8'h00); send_byte(8'h12); send_byte(8'hA5); send_byte(8'hF0); send_byte(8'h80);
        check_cnt++; if (wq_addr.size() !== base) $display("[TB] FAIL sync_early_write: got %0d want %0d", wq_addr.size(), base); else pass_cnt++;
        send_byte(8'h1F);
        @(negedge clk);
        check_cnt++; if (wr_en !== 1'b1) $display("[TB] FAIL sync_wr_en: got %0b want 1", wr_en); else pass_cnt++;
        check_cnt++; if (wr_addr !== 14'h0) $display("[TB] FAIL sync_wr_addr: got %0h want 0", wr_addr); else pass_cnt++;
        check_cnt++; if (wr_data !== 12'hF81) $display("[TB] FAIL sync_wr_data: got %0h want f81", wr_data); else pass_cnt++;
        @(posedge clk); #1;
        check_cnt++; if (wq_addr.size() !== base + 1) $display("[TB] FAIL sync_one_write: got %0d want %0d", wq_addr.size(), base + 1); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (wr_en !== 1'b0) $display("[TB] FAIL sync_wr_en_drop: got %0b want 0", wr_en); else pass_cnt++;
        check_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL sync_back_to_r: got %0b want 1", in_ready); else pass_cnt++;
        check_cnt++; if (wr_addr !== 14'h1) $display("[TB] FAIL sync_next_addr: got %0h want 1", wr_addr); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    // Continues the frame from test_sync_hunt at pixel 1
    task automatic test_blank_gating();
        int base;
        $display("[TB] test_blank_gating");
        blank = 1'b0;
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        in_data = 8'h77; in_valid = 1'b1;
        base = wq_addr.size();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_cnt++; if (wr_en !== 1'b0) $display("[TB] FAIL gate_wr_en c%0d: got %0b want 0", k, wr_en); else pass_cnt++;
            check_cnt++; if (in_ready !== 1'b0) $display("[TB] FAIL gate_in_ready c%0d: got %0b want 0", k, in_ready); else pass_cnt++;
            check_cnt++; if (wr_addr !== 14'h1) $display("[TB] FAIL gate_wr_addr c%0d: got %0h want 1", k, wr_addr); else pass_cnt++;
            check_cnt++; if (wr_data !== 12'h135) $display("[TB] FAIL gate_wr_data c%0d: got %0h want 135", k, wr_data); else pass_cnt++;
        end
        @(posedge clk); #1;
        blank = 1'b1;
        @(negedge clk);
        check_cnt++; if (wr_en !== 1'b1) $display("[TB] FAIL gate_release_wr_en: got %0b want 1", wr_en); else pass_cnt++;
        check_cnt++; if (wr_addr !== 14'h1) $display("[TB] FAIL gate_release_addr: got %0h want 1", wr_addr); else pass_cnt++;
        @(posedge clk); #1;
        check_cnt++; if (wq_addr.size() !== base + 1) $display("[TB] FAIL gate_one_write: got %0d want %0d", wq_addr.size(), base + 1); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL gate_to_get_r: got %0b want 1", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        send_byte(8'hA5); send_byte(8'h3C);
        @(negedge clk);
        check_cnt++; if (wr_addr !== 14'h2) $display("[TB] FAIL held_byte_addr: got %0h want 2", wr_addr); else pass_cnt++;
        check_cnt++; if (wr_data !== 12'h7A3) $display("[TB] FAIL held_byte_data: got %0h want 7a3", wr_data); else pass_cnt++;
        @(posedge clk); #1;
        send_byte(8'hA5); send_byte(8'hA5); send_byte(8'hA5);
        @(negedge clk);
        check_cnt++; if (wr_addr !== 14'h3) $display("[TB] FAIL sof_in_data_addr: got %0h want 3", wr_addr); else pass_cnt++;
        check_cnt++; if (wr_data !== 12'hAAA) $display("[TB] FAIL sof_in_data_data: got %0h want aaa", wr_data); else pass_cnt++;
        @(posedge clk); #1;
        pulse_abort();
        @(negedge clk);
        check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL gate_abort_busy: got %0b want 0", busy); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int base;
        $display("[TB] test_abort");
        blank = 1'b1;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL start_abort_busy: got %0b want 0", busy); else pass_cnt++;
        @(posedge clk); #1;
        pulse_start();
        send_byte(8'hA5);
        base = wq_addr.size();
        for (int i = 0; i < 37; i++) send_pixel(i);
        send_byte(pr(37));
        abort = 1'b1;
        @(negedge clk);
        check_cnt++; if (wr_en !== 1'b0) $display("[TB] FAIL abort_g_wr_en: got %0b want 0", wr_en); else pass_cnt++;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL abort_g_busy: got %0b want 0", busy); else pass_cnt++;
        check_cnt++; if (wr_addr !== 14'h0) $display("[TB] FAIL abort_g_addr: got %0h want 0", wr_addr); else pass_cnt++;
        @(posedge clk); #1;
        check_cnt++; if (wq_addr.size() - base !== 37) $display("[TB] FAIL abort_g_count: got %0d want 37", wq_addr.size() - base); else pass_cnt++;
        check_cnt++; if (wq_addr[wq_addr.size() - 1] !== 14'd36) $display("[TB] FAIL abort_g_last: got %0d want 36", wq_addr[wq_addr.size() - 1]); else pass_cnt++;
        // abort landing in the WRITE cycle itself
        pulse_start();
        send_byte(8'hA5);
        base = wq_addr.size();
        send_pixel(0);
        abort = 1'b1;
        @(negedge clk);
        check_cnt++; if (wr_en !== 1'b0) $display("[TB] FAIL abort_w_wr_en: got %0b want 0", wr_en); else pass_cnt++;
        @(posedge clk); #1;
        abort = 1'b0;
        check_cnt++; if (wq_addr.size() !== base) $display("[TB] FAIL abort_w_count: got %0d want %0d", wq_addr.size(), base); else pass_cnt++;
        pulse_start();
        send_byte(8'hA5);
        send_pixel(5);
        @(negedge clk);
        check_cnt++; if (wr_en !== 1'b1) $display("[TB] FAIL restart_wr_en: got %0b want 1", wr_en); else pass_cnt++;
        check_cnt++; if (wr_addr !== 14'h0) $display("[TB] FAIL restart_addr: got %0h want 0", wr_addr); else pass_cnt++;
        check_cnt++; if (wr_data !== pexp(5)) $display("[TB] FAIL restart_data: got %0h want %0h", wr_data, pexp(5)); else pass_cnt++;
        @(posedge clk); #1;
        pulse_abort();
    endtask

    task automatic test_back_pressure();
        int base;
        int bad;
        int gap;
        $display("[TB] test_back_pressure");
        blank = 1'b1;
        pulse_start();
        send_byte(8'hA5);
        base = wq_addr.size();
        for (int i = 0; i < 20; i++) begin
            for (int ch = 0; ch < 3; ch++) begin
                gap = $urandom_range(0, 3);
                repeat (gap) begin
                    in_data = 8'($urandom);
                    tick();
                end
                if (ch == 0) send_byte(pr(i + 100));
                else if (ch == 1) send_byte(pg(i + 100));
                else send_byte(pb(i + 100));
            end
            if (i % 3 == 1) begin
                blank = 1'b0;
                repeat (3) tick();
                blank = 1'b1;
            end
            if (i == 10) pulse_start();
        end
        repeat (2) tick();
        check_cnt++; if (wq_addr.size() - base !== 20) $display("[TB] FAIL bp_count: got %0d want 20", wq_addr.size() - base); else pass_cnt++;
        bad = -1;
        for (int i = 0; i < 20 && base + i < wq_addr.size(); i++) begin
            if (bad < 0 && (wq_addr[base + i] !== 14'(i) || wq_data[base + i] !== pexp(i + 100))) bad = i;
        end
        check_cnt++; if (bad !== -1) $display("[TB] FAIL bp_pixels: first bad pixel %0d want none", bad); else pass_cnt++;
        check_cnt++; if (busy !== 1'b1) $display("[TB] FAIL bp_still_busy: got %0b want 1", busy); else pass_cnt++;
        pulse_abort();
    endtask

    task automatic test_async_reset();
        $display("[TB] test_async_reset");
        blank = 1'b1;
        pulse_start();
        send_byte(8'hA5);
        send_pixel(1); send_pixel(2);
        send_byte(pr(3));
        #2;
        rst_n = 1'b0;
        #1;
        check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL arst_busy: got %0b want 0", busy); else pass_cnt++;
        check_cnt++; if (wr_addr !== 14'h0) $display("[TB] FAIL arst_addr: got %0h want 0", wr_addr); else pass_cnt++;
        check_cnt++; if (wr_data !== 12'h0) $display("[TB] FAIL arst_data: got %0h want 0", wr_data); else pass_cnt++;
        check_cnt++; if (in_ready !== 1'b0) $display("[TB] FAIL arst_in_ready: got %0b want 0", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_frame();
        int base;
        int base_fd;
        int n;
        int addr_err;
        int data_err;
        int gap_err;
        $display("[TB] test_full_frame");
        blank = 1'b1;
        pulse_start();
        send_byte(8'hA5);
        base = wq_addr.size();
        base_fd = fd_cnt;
        for (int i = 0; i < 16384; i++) send_pixel(i);
        @(negedge clk);
        check_cnt++; if (wr_en !== 1'b1) $display("[TB] FAIL ff_last_wr_en: got %0b want 1", wr_en); else pass_cnt++;
        check_cnt++; if (wr_addr !== 14'h3FFF) $display("[TB] FAIL ff_last_addr: got %0h want 3fff", wr_addr); else pass_cnt++;
        @(posedge clk); #1;
        @(negedge clk);
        check_cnt++; if (frame_done !== 1'b1) $display("[TB] FAIL ff_done_pulse: got %0b want 1", frame_done); else pass_cnt++;
        check_cnt++; if (busy !== 1'b1) $display("[TB] FAIL ff_busy_in_done: got %0b want 1", busy); else pass_cnt++;
        @(posedge clk); #1;
        @(negedge clk);
        check_cnt++; if (frame_done !== 1'b0) $display("[TB] FAIL ff_done_drop: got %0b want 0", frame_done); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL ff_busy_drop: got %0b want 0", busy); else pass_cnt++;
        @(posedge clk); #1;
        n = wq_addr.size() - base;
        check_cnt++; if (n !== 16384) $display("[TB] FAIL ff_count: got %0d want 16384", n); else pass_cnt++;
        addr_err = -1; data_err = -1; gap_err = -1;
        for (int i = 0; i < n && i < 16384; i++) begin
            if (addr_err < 0 && wq_addr[base + i] !== 14'(i)) addr_err = i;
            if (data_err < 0 && wq_data[base + i] !== pexp(i)) data_err = i;
            if (gap_err < 0 && i > 0 && (wq_cyc[base + i] - wq_cyc[base + i - 1]) !== 4) gap_err = i;
        end
        check_cnt++; if (addr_err !== -1) $display("[TB] FAIL ff_addr_seq: first bad index %0d want none", addr_err); else pass_cnt++;
        check_cnt++; if (data_err !== -1) $display("[TB] FAIL ff_data_seq: first bad index %0d want none", data_err); else pass_cnt++;
        check_cnt++; if (gap_err !== -1) $display("[TB] FAIL ff_spacing: first bad index %0d want none", gap_err); else pass_cnt++;
        check_cnt++; if (fd_cnt - base_fd !== 1) $display("[TB] FAIL ff_done_count: got %0d want 1", fd_cnt - base_fd); else pass_cnt++;
        check_cnt++; if (fd_cyc !== wq_cyc[wq_cyc.size() - 1] + 1) $display("[TB] FAIL ff_done_timing: got %0d want %0d", fd_cyc, wq_cyc[wq_cyc.size() - 1] + 1); else pass_cnt++;
        pulse_start();
        send_byte(8'hA5);
        send_pixel(9);
        @(negedge clk);
        check_cnt++; if (wr_en !== 1'b1) $display("[TB] FAIL ff2_wr_en: got %0b want 1", wr_en); else pass_cnt++;
        check_cnt++; if (wr_addr !== 14'h0) $display("[TB] FAIL ff2_addr: got %0h want 0", wr_addr); else pass_cnt++;
        check_cnt++; if (wr_data !== pexp(9)) $display("[TB] FAIL ff2_data: got %0h want %0h", wr_data, pexp(9)); else pass_cnt++;
        @(posedge clk); #1;
        pulse_abort();
    endtask

    task automatic test_no_timeouts();
        check_cnt++; if (timeout_cnt !== 0) $display("[TB] FAIL handshake_timeouts: got %0d want 0", timeout_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_sync_hunt();
        test_blank_gating();
        test_abort();
        test_back_pressure();
        test_async_reset();
        test_full_frame();
        test_no_timeouts();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
